// File: rtl/move_pkg.sv
// Shared definitions for the move sequencer: state encoding and default widths.
package move_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int LW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/move_addr_cnt.sv
// Source/destination address and remaining-word registers for one move command.
module move_addr_cnt
  import move_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int LW   = LW_DEF,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] ld_src,
  input  logic [AW-1:0] ld_dst,
  input  logic [LW-1:0] ld_len,
  output logic [AW-1:0] src,
  output logic [AW-1:0] dst,
  output logic [LW-1:0] count
);

  // Addresses wrap silently modulo 2^AW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src   <= '0;
      dst   <= '0;
      count <= '0;
    end else if (load) begin
      src   <= ld_src;
      dst   <= ld_dst;
      count <= ld_len;
    end else if (step) begin
      src   <= src + AW'(STEP);
      dst   <= dst + AW'(STEP);
      count <= count - LW'(1);
    end
  end

endmodule

// File: rtl/move_seq.sv
// Move sequencer: copies len words from src to dst, one outstanding read at a time.
//  state   | meaning
//  IDLE    | waiting for a command, cmd_ready high
//  RD_REQ  | read request presented at src
//  RD_WAIT | waiting for read data
//  WR_REQ  | write of buffered word presented at dst
//  DONE    | one-cycle completion pulse
module move_seq
  import move_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int LW   = LW_DEF,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [LW-1:0] cmd_len,
  input  logic          abort,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_rsp_valid,
  input  logic [DW-1:0] rd_rsp_data,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] words_left
);

  state_t        state, state_nxt;
  logic          load, step, buf_en;
  logic [DW-1:0] buf_q;
  logic [AW-1:0] src_q, dst_q;
  logic [LW-1:0] cnt_q;

  move_addr_cnt #(.AW(AW), .LW(LW), .STEP(STEP)) u_addr_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .ld_src (cmd_src),
    .ld_dst (cmd_dst),
    .ld_len (cmd_len),
    .src    (src_q),
    .dst    (dst_q),
    .count  (cnt_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       buf_q <= '0;
    else if (buf_en) buf_q <= rd_rsp_data;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    buf_en    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load      = 1'b1;
          state_nxt = (cmd_len == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ:  if (rd_ready) state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (rd_rsp_valid) begin
          buf_en    = 1'b1;
          state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        if (wr_ready) begin
          step      = 1'b1;
          state_nxt = (cnt_q == LW'(1)) ? DONE : RD_REQ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over any progress; a same-cycle handshake still reaches memory.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      step      = 1'b0;
      buf_en    = 1'b0;
    end
  end

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign rd_valid   = (state == RD_REQ);
  assign wr_valid   = (state == WR_REQ);
  assign done       = (state == DONE) && !abort;
  assign rd_addr    = src_q;
  assign wr_addr    = dst_q;
  assign wr_data    = buf_q;
  assign words_left = cnt_q;

endmodule

// File: tb/tb_move_seq.sv
// Self-checking bench for move_seq: memory-side responder plus a copy-semantics reference model.
module tb_move_seq;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_src, cmd_dst, cmd_len;
  logic        abort;
  logic        rd_valid, rd_ready, rd_rsp_valid;
  logic [15:0] rd_addr, rd_rsp_data;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_addr, wr_data;
  logic        busy, done;
  logic [15:0] words_left;

  move_seq dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .abort(abort),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .words_left(words_left)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] rd_log[$];
  logic [15:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];

  int cyc = 0, wr_last_cyc = 0, acc_cyc = 0;
  int rd_stall_cfg = 0, wr_stall_cfg = 0, rsp_delay_cfg = 0;
  bit rand_mode = 0, track = 0;
  int exp_len = 0, rd_base = 0, wr_base = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory side: ready/stall decisions and read responses are made at the falling edge.
  initial begin
    int rd_stall_left, wr_stall_left, rsp_cnt;
    bit rd_stalled, wr_stalled;
    logic [15:0] rd_hold_addr, wr_hold_addr, wr_hold_data, rsp_data;
    rd_stall_left = 0; wr_stall_left = 0; rsp_cnt = -1;
    rd_stalled = 0; wr_stalled = 0;
    rd_hold_addr = '0; wr_hold_addr = '0; wr_hold_data = '0; rsp_data = '0;
    rd_ready = 0; wr_ready = 0; rd_rsp_valid = 0; rd_rsp_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rd_stalled = 0; wr_stalled = 0; rsp_cnt = -1;
        rd_ready = 0; wr_ready = 0; rd_rsp_valid = 0;
        continue;
      end
      if (!busy) begin
        rd_stall_left = rd_stall_cfg;
        wr_stall_left = wr_stall_cfg;
      end
      if (rsp_cnt == 0) begin
        rd_rsp_valid = 1; rd_rsp_data = rsp_data; rsp_cnt = -1;
      end else begin
        rd_rsp_valid = 0;
        if (rsp_cnt > 0) rsp_cnt--;
      end
      if (track && busy)
        chk("words_left", 32'(words_left), 32'(exp_len - (wr_addr_log.size() - wr_base)));
      if (rd_stalled && !abort) begin
        chk("rd_hold_valid", 32'(rd_valid), 32'd1);
        chk("rd_hold_addr", 32'(rd_addr), 32'(rd_hold_addr));
      end
      if (wr_stalled && !abort) begin
        chk("wr_hold_valid", 32'(wr_valid), 32'd1);
        chk("wr_hold_addr", 32'(wr_addr), 32'(wr_hold_addr));
        chk("wr_hold_data", 32'(wr_data), 32'(wr_hold_data));
      end
      rd_stalled = 0; wr_stalled = 0; rd_ready = 0; wr_ready = 0;
      if (rd_valid) begin
        if (rd_stall_left > 0) begin
          rd_stall_left--; rd_stalled = 1; rd_hold_addr = rd_addr;
        end else begin
          rd_ready = 1;
          rd_log.push_back(rd_addr);
          rsp_data = mem[rd_addr];
          rsp_cnt = rand_mode ? int'($urandom_range(0, 2)) : rsp_delay_cfg;
          rd_stall_left = rand_mode ? int'($urandom_range(0, 3)) : rd_stall_cfg;
        end
      end
      if (wr_valid) begin
        if (wr_stall_left > 0) begin
          wr_stall_left--; wr_stalled = 1; wr_hold_addr = wr_addr; wr_hold_data = wr_data;
        end else begin
          wr_ready = 1;
          wr_addr_log.push_back(wr_addr);
          wr_data_log.push_back(wr_data);
          wr_last_cyc = cyc;
          wr_stall_left = rand_mode ? int'($urandom_range(0, 3)) : wr_stall_cfg;
        end
      end
    end
  end

  task automatic start_cmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] len,
                           input bit ab);
    int n;
    cmd_src = s; cmd_dst = d; cmd_len = len; cmd_valid = 1;
    if (ab) abort = 1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    exp_len = int'(len); rd_base = rd_log.size(); wr_base = wr_addr_log.size();
    acc_cyc = cyc; track = 1;
    tick();
    cmd_valid = 0; abort = 0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("rd_valid_T1", 32'(rd_valid), 32'(len != 0));
  endtask

  // Reference: word i is read from s+i and written to d+i with mem[s+i], addresses mod 2^16.
  task automatic finish_cmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] len);
    int n;
    n = 0;
    while (!done && n < 400) begin tick(); n++; end
    chk("done_seen", 32'(done), 32'd1);
    chk("done_cycle", 32'(cyc), 32'((len == 0) ? acc_cyc + 1 : wr_last_cyc + 1));
    tick();
    track = 0;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
    chk("n_reads", 32'(rd_log.size() - rd_base), 32'(len));
    chk("n_writes", 32'(wr_addr_log.size() - wr_base), 32'(len));
    for (int i = 0; i < int'(len) && rd_base + i < rd_log.size()
                    && wr_base + i < wr_addr_log.size(); i++) begin
      logic [15:0] sa, da;
      sa = 16'(s + 16'(i));
      da = 16'(d + 16'(i));
      chk("rd_addr", 32'(rd_log[rd_base + i]), 32'(sa));
      chk("wr_addr", 32'(wr_addr_log[wr_base + i]), 32'(da));
      chk("wr_data", 32'(wr_data_log[wr_base + i]), 32'(mem[sa]));
    end
  endtask

  initial begin
    int n;
    logic [15:0] s, d, l;
    reset = 1; cmd_valid = 0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; abort = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0100] = 16'h00A1; mem[16'h0101] = 16'h00A2; mem[16'h0102] = 16'h00A3;

    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_words_left", 32'(words_left), 32'd0);
    tick();
    reset = 0;
    tick();

    // Single copy with immediate ready and next-cycle responses.
    start_cmd(16'h0100, 16'h0200, 16'd3, 0);
    finish_cmd(16'h0100, 16'h0200, 16'd3);
    for (int i = 0; i < 3 && wr_base + i < wr_data_log.size(); i++)
      chk("single_wr_data", 32'(wr_data_log[wr_base + i]), 32'h00A1 + 32'(i));

    // Zero length: straight to DONE with no memory traffic.
    start_cmd(16'h0300, 16'h0400, 16'd0, 0);
    finish_cmd(16'h0300, 16'h0400, 16'd0);

    // Backpressure on both ports.
    rd_stall_cfg = 4; wr_stall_cfg = 5;
    start_cmd(16'h1000, 16'h2000, 16'd2, 0);
    finish_cmd(16'h1000, 16'h2000, 16'd2);
    rd_stall_cfg = 0; wr_stall_cfg = 0;

    // Address wrap.
    start_cmd(16'hFFFF, 16'hFFFE, 16'd3, 0);
    finish_cmd(16'hFFFF, 16'hFFFE, 16'd3);

    // Abort while waiting for the second word's read data.
    rsp_delay_cfg = 3;
    start_cmd(16'h0500, 16'h0600, 16'd5, 0);
    n = 0;
    while ((rd_log.size() - rd_base) < 2 && n < 100) begin tick(); n++; end
    chk("abort_reached_rd2", 32'(rd_log.size() - rd_base), 32'd2);
    tick();
    abort = 1;
    tick();
    abort = 0;
    track = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_writes", 32'(wr_addr_log.size() - wr_base), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      tick();
    end
    rsp_delay_cfg = 0;

    // Command accepted even with abort high in IDLE.
    start_cmd(16'h0700, 16'h0800, 16'd2, 1);
    finish_cmd(16'h0700, 16'h0800, 16'd2);

    // Asynchronous reset while a write is stalled.
    wr_stall_cfg = 20;
    start_cmd(16'h0900, 16'h0A00, 16'd4, 0);
    n = 0;
    while (!wr_valid && n < 100) begin tick(); n++; end
    chk("reset_reached_wr", 32'(wr_valid), 32'd1);
    #2 reset = 1;
    #1;
    chk("mrst_wr_valid", 32'(wr_valid), 32'd0);
    chk("mrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mrst_words_left", 32'(words_left), 32'd0);
    chk("mrst_wr_data", 32'(wr_data), 32'd0);
    track = 0;
    wr_stall_cfg = 0;
    tick();
    reset = 0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    start_cmd(16'h0B00, 16'h0C00, 16'd3, 0);
    finish_cmd(16'h0B00, 16'h0C00, 16'd3);

    // Randomized commands with random stalls and response delays.
    rand_mode = 1;
    for (int k = 0; k < 8; k++) begin
      s = 16'($urandom);
      d = 16'($urandom);
      l = 16'($urandom_range(0, 6));
      start_cmd(s, d, l, 0);
      finish_cmd(s, d, l);
    end
    rand_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
